// File: rtl/decode_regfile_stage_if.sv
// Bus between the decode/register-read stage and its neighbours: fetch-side
// instruction handshake, writeback port, execute load tag and the decoded bundle.
interface decode_regfile_stage_if #(
  parameter int WIDTH = 16
);
  // fetch side
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  // writeback port
  logic             wb_en;
  logic [2:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  // load currently in execute
  logic             ex_load_valid;
  logic [2:0]       ex_load_rd;
  // decoded bundle to execute
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu1;
  logic [WIDTH-1:0] alu2;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] storedata;
  logic [WIDTH-1:0] pc_out;
  logic [3:0]       opcode;
  logic [2:0]       regaddress;
  logic             writereg;
  logic [1:0]       memwrite;
  logic             isbranch;
  logic [2:0]       cond;
  logic             halt;

  // surrounding pipeline view
  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data,
           ex_load_valid, ex_load_rd, out_ready,
    input  in_ready, out_valid, alu1, alu2, address, storedata, pc_out,
           opcode, regaddress, writereg, memwrite, isbranch, cond, halt
  );

  // decode stage view
  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data,
           ex_load_valid, ex_load_rd, out_ready,
    output in_ready, out_valid, alu1, alu2, address, storedata, pc_out,
           opcode, regaddress, writereg, memwrite, isbranch, cond, halt
  );
endinterface

// File: rtl/decode_regfile_stage.sv
// Decode / register-read stage: 8-entry register file, one 16-bit instruction
// decoded per cycle into a registered valid/ready bundle for execute.
// Handles writeback bypass, load-use stall and a sticky halt.
module decode_regfile_stage #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  decode_regfile_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] alu1;
    logic [WIDTH-1:0] alu2;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] storedata;
    logic [WIDTH-1:0] pc;
    logic [3:0]       opcode;
    logic [2:0]       regaddress;
    logic             writereg;
    logic [1:0]       memwrite;
    logic             isbranch;
    logic [2:0]       cond;
  } bundle_t;

  logic [7:0][WIDTH-1:0] regs;
  logic [7:0][WIDTH-1:0] view;   // register values as seen by this cycle's reads

  bundle_t          nxt, out_q;
  logic             out_vld, halt_q, rdy_q;
  logic [7:0]       use_mask;    // registers the instruction actually reads
  logic             is_hlt;
  logic [1:0]       cls;
  logic [2:0]       fa, fb;
  logic [3:0]       fop;
  logic [WIDTH-1:0] sext8;
  logic             hazard, advance, ready, take;

  // Read view: hard-zero r0 first, then same-cycle writeback forwarding.
  for (genvar k = 0; k < 8; k++) begin : g_view
    assign view[k] = (ZERO_R0 && k == 0) ? '0 :
                     (BYPASS && bus.wb_en && bus.wb_addr == 3'(k)) ? bus.wb_data :
                     regs[k];
  end

  // Register file write; r0 writes are dropped when it is hard-wired to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '0;
    end else if (bus.wb_en && !(ZERO_R0 && bus.wb_addr == 3'd0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign cls   = bus.in_instr[15:14];
  assign fa    = bus.in_instr[13:11];
  assign fb    = bus.in_instr[10:8];
  assign fop   = bus.in_instr[7:4];
  assign sext8 = {{(WIDTH-8){bus.in_instr[7]}}, bus.in_instr[7:0]};

  // Instruction decode into the next bundle plus its source-register set.
  always_comb begin
    nxt      = '0;
    nxt.pc   = bus.in_pc;
    use_mask = 8'h00;
    is_hlt   = 1'b0;
    // all-zero word is a NOP rather than LD r0,0(r0)
    if (bus.in_instr != 16'h0000) begin
      case (cls)
        2'd3: begin // ALU
          nxt.alu1       = view[fa];
          nxt.opcode     = fop;
          nxt.alu2       = (fop <= 4'd8) ? view[fb] : {{(WIDTH-4){1'b0}}, bus.in_instr[3:0]};
          nxt.writereg   = !(fop == 4'd5 || fop >= 4'd12);
          nxt.regaddress = fb;
          use_mask[fa]   = 1'b1;
          if (fop <= 4'd8) use_mask[fb] = 1'b1;
          is_hlt         = (fop == 4'd15);
        end
        2'd0: begin // LD
          nxt.regaddress = fa;
          nxt.address    = view[fb] + sext8;
          nxt.writereg   = 1'b1;
          nxt.memwrite   = 2'b01;
          use_mask[fb]   = 1'b1;
        end
        2'd1: begin // ST
          nxt.address    = view[fb] + sext8;
          nxt.storedata  = view[fa];
          nxt.memwrite   = 2'b10;
          use_mask[fb]   = 1'b1;
          use_mask[fa]   = 1'b1;
        end
        default: begin // class 2: LI / B / Bcc, rest are NOPs
          case (fa)
            3'b000: begin
              nxt.alu1       = sext8;
              nxt.opcode     = 4'd6;
              nxt.regaddress = fb;
              nxt.writereg   = 1'b1;
            end
            3'b100: begin
              nxt.isbranch = 1'b1;
              nxt.address  = sext8;
            end
            3'b111: begin
              nxt.isbranch = 1'b1;
              nxt.cond     = fb;
              nxt.address  = sext8;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign hazard  = bus.ex_load_valid && use_mask[bus.ex_load_rd];
  assign advance = !out_vld || bus.out_ready;
  // rdy_q holds ready low for the first cycle out of reset
  assign ready   = advance && !hazard && !halt_q && rdy_q;
  assign take    = bus.in_valid && ready;

  // Output register: load on transfer, bubble on a free slot, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      out_vld <= 1'b0;
      halt_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (take) begin
        out_q   <= nxt;
        out_vld <= 1'b1;
        if (is_hlt) halt_q <= 1'b1;
      end else if (advance) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_vld;
  assign bus.alu1       = out_q.alu1;
  assign bus.alu2       = out_q.alu2;
  assign bus.address    = out_q.address;
  assign bus.storedata  = out_q.storedata;
  assign bus.pc_out     = out_q.pc;
  assign bus.opcode     = out_q.opcode;
  assign bus.regaddress = out_q.regaddress;
  assign bus.writereg   = out_q.writereg;
  assign bus.memwrite   = out_q.memwrite;
  assign bus.isbranch   = out_q.isbranch;
  assign bus.cond       = out_q.cond;
  assign bus.halt       = halt_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Bench for decode_regfile_stage: two instances (16-bit/bypass, 32-bit/zero-r0/
// no-bypass) share one stimulus stream and are checked against a spec-level model.
module tb_decode_regfile_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // shared stimulus
  logic        s_iv, s_elv, s_ordy, s_wb_en;
  logic [15:0] s_instr;
  logic [31:0] s_pc, s_wb_data;
  logic [2:0]  s_wb_addr, s_erd;

  decode_regfile_stage_if #(.WIDTH(16)) b0 ();
  decode_regfile_stage_if #(.WIDTH(32)) b1 ();

  assign b0.in_valid = s_iv;          assign b1.in_valid = s_iv;
  assign b0.in_instr = s_instr;       assign b1.in_instr = s_instr;
  assign b0.in_pc = s_pc[15:0];       assign b1.in_pc = s_pc;
  assign b0.wb_en = s_wb_en;          assign b1.wb_en = s_wb_en;
  assign b0.wb_addr = s_wb_addr;      assign b1.wb_addr = s_wb_addr;
  assign b0.wb_data = s_wb_data[15:0]; assign b1.wb_data = s_wb_data;
  assign b0.ex_load_valid = s_elv;    assign b1.ex_load_valid = s_elv;
  assign b0.ex_load_rd = s_erd;       assign b1.ex_load_rd = s_erd;
  assign b0.out_ready = s_ordy;       assign b1.out_ready = s_ordy;

  decode_regfile_stage #(.WIDTH(16), .ZERO_R0(1'b0), .BYPASS(1'b1)) d0 (
    .clock(clock), .reset(reset), .bus(b0));
  decode_regfile_stage #(.WIDTH(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) d1 (
    .clock(clock), .reset(reset), .bus(b1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] alu1, alu2, address, storedata, pc;
    logic [3:0]  op;
    logic [2:0]  ra;
    logic        wr;
    logic [1:0]  mw;
    logic        br;
    logic [2:0]  cond;
  } bun_t;

  logic [31:0] R [2][8];
  logic        m_ov  [2];
  logic        m_hlt [2];
  bun_t        m_b   [2];
  logic        m_rdy;

  function automatic logic [31:0] msk(input int m);
    return (m == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // instance 0: bypass on, r0 normal; instance 1: bypass off, r0 hard zero
  function automatic logic [31:0] rd_reg(input int m, input logic [2:0] a);
    if (m == 1 && a == 3'd0) return 32'd0;
    if (m == 0 && s_wb_en && s_wb_addr == a) return s_wb_data & msk(m);
    return R[m][a];
  endfunction

  function automatic bun_t model_decode(input int m);
    bun_t b;
    logic [15:0] i;
    logic [31:0] sx;
    i = s_instr;
    b = '0;
    b.pc = s_pc & msk(m);
    sx = {{24{i[7]}}, i[7:0]} & msk(m);
    if (i == 16'h0000) return b;
    case (i[15:14])
      2'd3: begin
        b.alu1 = rd_reg(m, i[13:11]);
        b.op   = i[7:4];
        b.alu2 = (i[7:4] <= 4'd8) ? rd_reg(m, i[10:8]) : {28'd0, i[3:0]};
        b.wr   = !(i[7:4] inside {4'd5, 4'd12, 4'd13, 4'd14, 4'd15});
        b.ra   = i[10:8];
      end
      2'd0: begin
        b.ra = i[13:11]; b.wr = 1'b1; b.mw = 2'b01;
        b.address = (rd_reg(m, i[10:8]) + sx) & msk(m);
      end
      2'd1: begin
        b.mw = 2'b10;
        b.address = (rd_reg(m, i[10:8]) + sx) & msk(m);
        b.storedata = rd_reg(m, i[13:11]);
      end
      default: begin
        if (i[13:11] == 3'b000) begin
          b.alu1 = sx; b.op = 4'd6; b.ra = i[10:8]; b.wr = 1'b1;
        end else if (i[13:11] == 3'b100) begin
          b.br = 1'b1; b.address = sx;
        end else if (i[13:11] == 3'b111) begin
          b.br = 1'b1; b.cond = i[10:8]; b.address = sx;
        end
      end
    endcase
    return b;
  endfunction

  function automatic logic model_hazard();
    logic [7:0] used;
    logic [15:0] i;
    i = s_instr;
    used = 8'h00;
    if (i != 16'h0000) begin
      case (i[15:14])
        2'd3: begin used[i[13:11]] = 1'b1; if (i[7:4] <= 4'd8) used[i[10:8]] = 1'b1; end
        2'd0: used[i[10:8]] = 1'b1;
        2'd1: begin used[i[10:8]] = 1'b1; used[i[13:11]] = 1'b1; end
        default: ;
      endcase
    end
    return s_elv && used[s_erd];
  endfunction

  function automatic logic model_ready(input int m);
    return (!m_ov[m] || s_ordy) && !model_hazard() && !m_hlt[m] && m_rdy;
  endfunction

  // model state advance at each rising edge
  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int k = 0; k < 8; k++) R[m][k] <= 32'd0;
        m_ov[m]  <= 1'b0;
        m_hlt[m] <= 1'b0;
        m_b[m]   <= '0;
      end else begin
        if (s_iv && model_ready(m)) begin
          m_b[m]  <= model_decode(m);
          m_ov[m] <= 1'b1;
          if (s_instr[15:14] == 2'd3 && s_instr[7:4] == 4'd15) m_hlt[m] <= 1'b1;
        end else if (!m_ov[m] || s_ordy) begin
          m_ov[m] <= 1'b0;
        end
        if (s_wb_en && !(m == 1 && s_wb_addr == 3'd0))
          R[m][s_wb_addr] <= s_wb_data & msk(m);
      end
    end
    m_rdy <= !reset;
  end

  task automatic cmp(input int m, input logic ov, input logic rdy, input logic hlt,
                     input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] ad,
                     input logic [31:0] sd, input logic [31:0] pc, input logic [3:0] op,
                     input logic [2:0] ra, input logic wr, input logic [1:0] mw,
                     input logic br, input logic [2:0] cd);
    chk($sformatf("d%0d out_valid", m), 32'(ov), 32'(m_ov[m]));
    chk($sformatf("d%0d in_ready", m), 32'(rdy), 32'(model_ready(m)));
    chk($sformatf("d%0d halt", m), 32'(hlt), 32'(m_hlt[m]));
    if (m_ov[m]) begin
      chk($sformatf("d%0d alu1", m), a1, m_b[m].alu1);
      chk($sformatf("d%0d alu2", m), a2, m_b[m].alu2);
      chk($sformatf("d%0d address", m), ad, m_b[m].address);
      chk($sformatf("d%0d storedata", m), sd, m_b[m].storedata);
      chk($sformatf("d%0d pc_out", m), pc, m_b[m].pc);
      chk($sformatf("d%0d ctrl", m), {20'd0, op, ra, wr, mw, br, cd},
          {20'd0, m_b[m].op, m_b[m].ra, m_b[m].wr, m_b[m].mw, m_b[m].br, m_b[m].cond});
    end
  endtask

  // compare process: every falling edge, both instances against the model
  always @(negedge clock) begin
    cmp(0, b0.out_valid, b0.in_ready, b0.halt, 32'(b0.alu1), 32'(b0.alu2),
        32'(b0.address), 32'(b0.storedata), 32'(b0.pc_out), b0.opcode,
        b0.regaddress, b0.writereg, b0.memwrite, b0.isbranch, b0.cond);
    cmp(1, b1.out_valid, b1.in_ready, b1.halt, b1.alu1, b1.alu2, b1.address,
        b1.storedata, b1.pc_out, b1.opcode, b1.regaddress, b1.writereg,
        b1.memwrite, b1.isbranch, b1.cond);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    s_iv = 0; s_instr = 16'h0000; s_pc = 32'h0; s_wb_en = 0; s_wb_addr = 0;
    s_wb_data = 0; s_elv = 0; s_erd = 0; s_ordy = 1;
  endtask

  task automatic wb(input logic [2:0] a, input logic [31:0] d);
    s_wb_en = 1; s_wb_addr = a; s_wb_data = d;
    tick();
    s_wb_en = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) tick();
    chk("reset out_valid", 32'(b0.out_valid), 0);
    chk("reset in_ready", 32'(b0.in_ready), 0);
    chk("reset halt", 32'(b0.halt), 0);
    chk("reset alu1", 32'(b0.alu1), 0);
    chk("reset address", b1.address, 0);
    chk("reset ctrl", {b0.writereg, b0.memwrite, b0.isbranch, b0.opcode}, 0);
    reset = 0;
    tick();
    chk("ready after reset", 32'(b0.in_ready), 1);

    // ADD r1,r2 -> alu1=5 alu2=3
    wb(3'd1, 32'h5);
    wb(3'd2, 32'h3);
    s_iv = 1; s_instr = 16'hCA00; s_pc = 32'h40;
    tick();
    s_iv = 0;
    chk("add out_valid", 32'(b0.out_valid), 1);
    chk("add alu1", 32'(b0.alu1), 32'h5);
    chk("add alu2", 32'(b0.alu2), 32'h3);
    chk("add wr/ra", {b0.writereg, b0.regaddress}, {1'b1, 3'd2});
    chk("add d1 alu2", b1.alu2, 32'h3);

    // LD r3,-2(r2) with r2=0x10
    wb(3'd2, 32'h10);
    s_iv = 1; s_instr = 16'h1AFE;
    tick();
    s_iv = 0;
    chk("ld address16", 32'(b0.address), 32'h000E);
    chk("ld address32", b1.address, 32'h0000_000E);
    chk("ld memwrite", 32'(b0.memwrite), 32'h1);
    chk("ld regaddress", 32'(b0.regaddress), 32'h3);

    // load-use hazard on r2
    s_elv = 1; s_erd = 3'd2; s_iv = 1; s_instr = 16'hCA00;
    #1 chk("hazard in_ready", 32'(b0.in_ready), 0);
    tick();
    chk("hazard bubble", 32'(b0.out_valid), 0);
    s_elv = 0;
    #1 chk("hazard cleared", 32'(b0.in_ready), 1);
    tick();
    chk("after hazard valid", 32'(b0.out_valid), 1);
    chk("after hazard alu2", 32'(b0.alu2), 32'h10);

    // ST r4 with same-cycle writeback of r4
    s_wb_en = 1; s_wb_addr = 3'd4; s_wb_data = 32'h1234; s_instr = 16'h6000;
    tick();
    s_wb_en = 0;
    chk("st bypass", 32'(b0.storedata), 32'h1234);
    chk("st no bypass", b1.storedata, 32'h0);
    chk("st memwrite", 32'(b1.memwrite), 32'h2);
    tick();
    chk("st regfile updated", b1.storedata, 32'h1234);

    // downstream stall for 3 cycles
    s_ordy = 0; s_instr = 16'h857F;
    repeat (3) begin
      tick();
      chk("stall valid", 32'(b0.out_valid), 1);
      chk("stall held", 32'(b0.storedata), 32'h1234);
      chk("stall in_ready", 32'(b0.in_ready), 0);
    end
    s_ordy = 1;
    #1 chk("release in_ready", 32'(b0.in_ready), 1);
    tick();
    chk("li alu1", 32'(b0.alu1), 32'h7F);
    chk("li ctrl", {b0.opcode, b0.regaddress, b0.writereg}, {4'd6, 3'd5, 1'b1});

    // Bcc cond 3, offset -4
    s_instr = 16'hBBFC;
    tick();
    chk("bcc flags", {b0.isbranch, b0.cond}, {1'b1, 3'd3});
    chk("bcc address16", 32'(b0.address), 32'hFFFC);
    chk("bcc address32", b1.address, 32'hFFFF_FFFC);

    // HLT is sticky
    s_instr = 16'hC0F0;
    tick();
    chk("hlt halt", 32'(b0.halt), 1);
    chk("hlt bundle", {b0.out_valid, b0.opcode, b0.writereg}, {1'b1, 4'd15, 1'b0});
    s_instr = 16'hCA00;
    repeat (3) begin
      tick();
      chk("halted in_ready", 32'(b1.in_ready), 0);
    end
    chk("halted drained", 32'(b0.out_valid), 0);
    s_iv = 0;
    reset = 1;
    tick();
    reset = 0;
    tick();
    chk("reset clears halt", 32'(b1.halt), 0);
    chk("ready after halt reset", 32'(b1.in_ready), 1);

    // r0 hard zero on instance 1 only
    wb(3'd0, 32'hFFFF_FFFF);
    s_iv = 1; s_instr = 16'hC000;
    tick();
    s_iv = 0;
    chk("r0 zero", b1.alu1, 32'h0);
    chk("r0 normal", 32'(b0.alu1), 32'hFFFF);

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      s_iv      = ($urandom % 4) != 0;
      s_instr   = 16'($urandom);
      if (s_instr[15:14] == 2'd3 && s_instr[7:4] == 4'd15 && ($urandom % 40) != 0)
        s_instr[7:4] = 4'd14;
      if (($urandom % 30) == 0) s_instr = 16'h0000;
      s_pc      = $urandom;
      s_wb_en   = $urandom % 2;
      s_wb_addr = 3'($urandom);
      s_wb_data = (($urandom % 4) == 0) ? 32'($urandom % 64) : $urandom;
      s_elv     = ($urandom % 4) == 0;
      s_erd     = 3'($urandom);
      s_ordy    = ($urandom % 4) != 0;
      reset     = ($urandom % 150) == 0;
      tick();
    end

    idle();
    reset = 0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
